prio_encoder_q: RTL

PRIO_ENCODER_Q -- requirements
Module: prio_encoder_q

---
 rtl/prio_pkg.sv | 13 +
 rtl/prio_sel.sv | 36 +++
 rtl/prio_encoder_q.sv | 81 ++++++++
 3 files changed

// File: rtl/prio_pkg.sv
// prio_pkg: shared constants for the priority encoder.
// Selection modes and output-stage state encoding.
package prio_pkg;

   localparam int MODE_LOW  = 0;
   localparam int MODE_HIGH = 1;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/prio_sel.sv
// prio_sel: stateless priority selector over a candidate vector.
// Reports the winning index, whether any and whether several exist.
module prio_sel
   import prio_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_LOW,
   parameter int W    = $clog2(N)
) (
   input  logic [N-1:0] cand,
   output logic [W-1:0] index,
   output logic         any,
   output logic         multi
);

   // Last assignment wins, so scan toward the preferred end.
   always_comb begin
      index = '0;
      if (MODE == MODE_HIGH) begin
         for (int i = 0; i < N; i++) begin
            if (cand[i]) index = W'(i);
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) index = W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves a residue iff two or more are set.
   always_comb begin
      any   = |cand;
      multi = |(cand & (cand - N'(1)));
   end

endmodule

// File: rtl/prio_encoder_q.sv
// prio_encoder_q: sticky request accumulator with a registered
// priority-encoded output stage and valid/ready style consumption.
module prio_encoder_q
   import prio_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_LOW,
   parameter int W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_in,
   input  logic [N-1:0] mask,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   output logic         out_multi,
   output logic [N-1:0] pending
);

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   cand;
   logic [W-1:0]   sel_idx;
   logic           sel_any;
   logic           sel_multi;
   logic           load;
   logic [N-1:0]   pop;

   assign cand      = pending & ~mask;
   assign out_valid = (state == HOLD);

   prio_sel #(
      .N    (N),
      .MODE (MODE),
      .W    (W)
   ) u_sel (
      .cand  (cand),
      .index (sel_idx),
      .any   (sel_any),
      .multi (sel_multi)
   );

   // State register for the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // Next state: fill when empty, drain when consumed with nothing left.
   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (sel_any) state_nxt = HOLD;
         HOLD:  if (out_ready && !sel_any) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Load whenever the output slot is free or being freed this cycle.
   always_comb begin
      load = sel_any && ((state == EMPTY) || out_ready);
      pop  = load ? (N'(1) << sel_idx) : '0;
   end

   // Pending accumulates requests; a new request beats a same-bit pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         out_idx   <= '0;
         out_multi <= 1'b0;
      end else begin
         pending <= (pending & ~pop) | req_in;
         if (load) begin
            out_idx   <= sel_idx;
            out_multi <= sel_multi;
         end
      end
   end

endmodule
